// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between two requesters.
// Registers the granted operands, captures the ALU result and owns the {N,Z,C,V} flag register.
module alu_scheduler #(
    parameter int unsigned W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    // requester 0
    input  logic         i_req0,
    input  logic [2:0]   i_op0,
    input  logic [W-1:0] i_a0,
    input  logic [W-1:0] i_b0,
    input  logic         i_setf0,
    // requester 1
    input  logic         i_req1,
    input  logic [2:0]   i_op1,
    input  logic [W-1:0] i_a1,
    input  logic [W-1:0] i_b1,
    input  logic         i_setf1,
    // completion and architectural state
    output logic         o_ack0,
    output logic         o_ack1,
    output logic [W-1:0] o_result,
    output logic [3:0]   o_flags,
    output logic         o_busy,
    // to / from the external ALU
    output logic [2:0]   o_alu_ctrl,
    output logic [W-1:0] o_alu_a,
    output logic [W-1:0] o_alu_b,
    input  logic [W-1:0] i_alu_y,
    input  logic         i_alu_n,
    input  logic         i_alu_z,
    input  logic         i_alu_co,
    input  logic         i_alu_ovf
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpRsb = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_t;

    state_t         r_state;
    logic           r_last;     // id of the requester served most recently
    logic           r_win;
    logic           r_setf;
    logic [W-1:0]   r_result;
    logic [3:0]     r_flags;
    logic           r_ack0;
    logic           r_ack1;
    logic           r_busy;
    logic [2:0]     r_alu_ctrl;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;

    logic           w_grant_valid;
    logic           w_grant_id;
    logic [2:0]     w_op;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic           w_setf;
    logic           w_arith;
    logic [3:0]     w_flags_next;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_grant_valid = i_req0 | i_req1;
        w_grant_id    = (i_req0 && i_req1) ? ~r_last : i_req1;
        w_op          = w_grant_id ? i_op1   : i_op0;
        w_a           = w_grant_id ? i_a1    : i_a0;
        w_b           = w_grant_id ? i_b1    : i_b0;
        w_setf        = w_grant_id ? i_setf1 : i_setf0;
    end

    // Logical codes leave C and V untouched.
    always_comb begin
        w_arith      = (r_alu_ctrl == OpAdd) || (r_alu_ctrl == OpSub) || (r_alu_ctrl == OpRsb);
        w_flags_next = r_flags;
        if (r_setf) begin
            w_flags_next[3] = i_alu_n;
            w_flags_next[2] = i_alu_z;
            if (w_arith) begin
                w_flags_next[1] = i_alu_co;
                w_flags_next[0] = i_alu_ovf;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_setf     <= 1'b0;
            r_result   <= '0;
            r_flags    <= 4'b0000;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_busy     <= 1'b0;
            r_alu_ctrl <= 3'b000;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_grant_valid) begin
                        r_alu_ctrl <= w_op;
                        r_alu_a    <= w_a;
                        r_alu_b    <= w_b;
                        r_win      <= w_grant_id;
                        r_setf     <= w_setf;
                        r_last     <= w_grant_id;
                        r_busy     <= 1'b1;
                        r_state    <= StExec;
                    end
                end
                StExec: begin
                    r_result <= i_alu_y;
                    r_flags  <= w_flags_next;
                    r_ack0   <= ~r_win;
                    r_ack1   <= r_win;
                    r_state  <= StDone;
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_ack0     = r_ack0;
    assign o_ack1     = r_ack1;
    assign o_result   = r_result;
    assign o_flags    = r_flags;
    assign o_busy     = r_busy;
    assign o_alu_ctrl = r_alu_ctrl;
    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares one combinational ALU (ALUcontrol[2:0], A, B -> Y, N, Z, CO, OVF; width W) between two requesters.
- Arbitrates round-robin, registers the winning operands into the ALU, and captures the result.
- Owns the architectural flag register {N,Z,C,V}.
- Sits between the datapath issue logic and the ALU instance. The ALU is instantiated outside this block.

Parameters:
- W, 3, data width of operands and result. Must match the attached ALU.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  reset, synchronous, active-high
- req0  in  1  requester 0 request; held high with operands stable until ack0
- op0  in  3  requester 0 ALU control code
- a0  in  W  requester 0 operand A
- b0  in  W  requester 0 operand B
- setf0  in  1  requester 0 flag-update enable (1 = update flags)
- req1, op1, a1, b1, setf1  in  1/3/W/W/1  requester 1, same meaning as requester 0
- ack0  out  1  one-cycle pulse: requester 0 operation complete, result valid
- ack1  out  1  one-cycle pulse: requester 1 operation complete, result valid
- result  out  W  registered ALU result of the last completed operation
- flags  out  4  registered {N,Z,C,V}
- busy  out  1  high while state is not IDLE
- alu_ctrl  out  3  to ALU ALUcontrol
- alu_a  out  W  to ALU A
- alu_b  out  W  to ALU B
- alu_y  in  W  from ALU Y
- alu_n, alu_z, alu_co, alu_ovf  in  1 each  from ALU flags

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; result=0; flags=4'b0000; ack0=ack1=0; busy=0.
  - alu_ctrl/alu_a/alu_b=0.
  - Round-robin pointer set so requester 0 wins the first tie.
  - rst dominates all other inputs.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request high: that requester wins.
  - Both high: the requester not served last wins, and the pointer updates to the winner.
  - At the edge: latch the winner's op/a/b into alu_ctrl/alu_a/alu_b; latch the winner id and its setf; go to EXEC.
- EXEC:
  - The ALU settles combinationally from the registered inputs.
  - At the edge: result <= alu_y; flags updated per the flag rules; go to DONE.
- DONE:
  - ack of the winner is high for exactly this cycle; the other ack stays 0.
  - result/flags are already valid.
  - Go to IDLE.
- Latency: request sampled in IDLE -> ack asserted 2 cycles later. Throughput is one operation per 3 cycles.
- Requester protocol:
  - Deassert req in the cycle after ack.
  - If req is still high when IDLE samples it, that is a new request.
  - Requests arriving while busy are ignored until IDLE.
  - Operand changes while busy have no effect, because operands are registered at grant.
- Flag rules (setf of winner = 1):
  - N <= alu_n and Z <= alu_z for every code.
  - C <= alu_co and V <= alu_ovf only for arithmetic codes 3'b000 ADD, 3'b001 SUB (A-B), 3'b010 RSB (B-A).
  - Codes 3'b011..3'b111 are logical and retain C and V.
- Flag rules (setf of winner = 0): flags unchanged; result still updated.
- result holds its value until the next EXEC edge. alu_* outputs hold their value until the next grant.
- Reset in EXEC or DONE aborts the operation: no ack is issued, and result/flags return to 0.
- ack0 and ack1 are never high simultaneously. busy=1 in EXEC and DONE.

Test Plan:
- W=3, reset, then req0 with op=000, a=011, b=101, setf0=1 -> ack0 exactly 2 cycles after grant; result=000, flags=N0 Z1 C1 V0; ack1 stays 0.
- req1 with op=000, a=011, b=001, setf1=1 -> result=100, flags=1001 (N=1, V=1, C=0, Z=0).
- Flags=1001, then req0 op=100 (logical), a=110, b=011, setf0=1 -> result is the ALU Y (010 for AND), N0 Z0, C/V retained (flags=0001); then setf0=0 op=000 a=111 b=001 -> result=000, flags unchanged=0001.
- req0 and req1 asserted in the same cycle and held, re-asserted after each ack -> grants alternate 0,1,0,1; first grant after reset goes to requester 0; one ack per 3 cycles.
- rst pulsed during EXEC of a req1 operation -> no ack1; next cycle result=000, flags=0000, busy=0; a subsequent tie grants requester 0.
- req0 dropped and a0 changed during EXEC -> result computed from the latched operands; ack0 still issued once.
